// File: rtl/data_cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller; read hits complete with no added cycles.
module data_cache_controller #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned INDEX_W   = 6,
  parameter int unsigned TAG_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int unsigned SETS  = 1 << INDEX_W;
  localparam int unsigned OFF_W = 1 + INDEX_W + TAG_W;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t state;

  // Word offset (byte bits dropped): {tag, index, word select}
  logic [OFF_W-1:0]   off_w;
  logic               word_sel;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  logic [SETS-1:0]    valid [2];
  logic [SETS-1:0]    victim;
  logic [TAG_W-1:0]   tags  [2][SETS];
  logic [63:0]        data  [2][SETS];

  logic [1:0]         hit_way;
  logic               hit;
  logic               hit_w;
  logic               fill_w;
  logic [63:0]        hit_line;

  assign off_w    = OFF_W'((address - BASE_ADDR) >> 2);
  assign word_sel = off_w[0];
  assign index    = off_w[1 +: INDEX_W];
  assign tag      = off_w[1 + INDEX_W +: TAG_W];

  always_comb begin
    hit_way = '0;
    for (int unsigned w = 0; w < 2; w++) begin
      hit_way[w] = valid[w][index] && (tags[w][index] == tag);
    end
  end

  assign hit      = |hit_way;
  assign hit_w    = hit_way[1];
  assign hit_line = data[hit_w][index];
  assign fill_w   = !valid[0][index] ? 1'b0 :
                    !valid[1][index] ? 1'b1 : victim[index];

  assign sram_address = address;
  assign sram_wdata   = wdata;
  assign sram_r_en    = (state == READ_MISS);
  assign sram_w_en    = (state == WRITE);

  always_comb begin
    ready = 1'b0;
    unique case (state)
      IDLE:      ready = !(MEM_R_EN || MEM_W_EN) || (MEM_R_EN && !MEM_W_EN && hit);
      READ_MISS: ready = sram_ready;
      WRITE:     ready = sram_ready;
      default:   ready = 1'b0;
    endcase
  end

  // Completion-cycle bypass takes precedence; the line is not yet in the array
  always_comb begin
    rdata = '0;
    if (state == READ_MISS && sram_ready) begin
      rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
    end else if (state == IDLE && hit) begin
      rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid[0] <= '0;
      valid[1] <= '0;
      victim   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            state <= WRITE;
            if (hit) begin
              valid[hit_w][index] <= 1'b0;
              victim[index]       <= hit_w;
            end
          end else if (MEM_R_EN) begin
            if (hit) victim[index] <= ~hit_w;
            else     state         <= READ_MISS;
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            valid[fill_w][index] <= 1'b1;
            victim[index]        <= ~fill_w;
            state                <= IDLE;
          end
        end
        WRITE: begin
          if (sram_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == READ_MISS && sram_ready) begin
      tags[fill_w][index] <= tag;
      data[fill_w][index] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller: table of cache transactions
// with a read-data scoreboard, an SRAM memory model, and reset/priority sequences.
module tb_data_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_r_en, sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mem   [int unsigned];

  always #5 clk = ~clk;

  data_cache_controller #(.BASE_ADDR(1024), .INDEX_W(6), .TAG_W(10)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          exp_hit;
    string       name;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [63:0] line_of(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'd7;
    return {word_of(base | 32'd4), word_of(base)};
  endfunction

  task automatic pop_check(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({name, " scoreboard empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({name, " rdata"}, rdata, e);
    end
  endtask

  // One request; a miss or write is served after two SRAM wait cycles.
  task automatic xact(input vec_t v);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    MEM_R_EN = v.rd; MEM_W_EN = v.wr; address = v.addr; wdata = v.wd;
    if (v.rd && !v.wr) exp_q.push_back(word_of(v.addr));
    @(negedge clk);
    if (v.exp_hit) begin
      check({v.name, " hit ready"}, ready, 1);
      check({v.name, " hit no sram_r_en"}, sram_r_en, 0);
      pop_check(v.name);
    end else begin
      check({v.name, " detect ready"}, ready, 0);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (c == 2) begin
          sram_ready = 1'b1;
          sram_rdata = line_of(v.addr);
        end
        check({v.name, " sram_r_en"}, sram_r_en, !v.wr);
        check({v.name, " sram_w_en"}, sram_w_en, v.wr);
        if (v.wr) begin
          check({v.name, " sram_address"}, sram_address, v.addr);
          check({v.name, " sram_wdata"}, sram_wdata, v.wd);
        end
        @(negedge clk);
        check({v.name, " busy ready"}, ready, c == 2);
      end
      if (v.wr) mem[v.addr] = v.wd;
      else      pop_check(v.name);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    sram_ready = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  initial begin
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    address = 32'd1024; wdata = '0; sram_rdata = '0; sram_ready = 1'b0;
    mem[32'd1024] = 32'h11111111;
    mem[32'd1028] = 32'h22222222;

    vecs.push_back('{1, 0, 32'd1024, 0, 0, "cold 1024"});
    vecs.push_back('{1, 0, 32'd1028, 0, 1, "b2b 1028"});
    vecs.push_back('{1, 0, 32'd1536, 0, 0, "fill tag1"});
    vecs.push_back('{1, 0, 32'd1024, 0, 1, "reread 1024"});
    vecs.push_back('{1, 0, 32'd2048, 0, 0, "tag2 evicts tag1"});
    vecs.push_back('{1, 0, 32'd1024, 0, 1, "1024 survives"});
    vecs.push_back('{1, 0, 32'd1536, 0, 0, "1536 evicted"});
    vecs.push_back('{0, 1, 32'd1024, 32'hDEADBEEF, 0, "write hit 1024"});
    vecs.push_back('{1, 0, 32'd1024, 0, 0, "refill 1024"});
    vecs.push_back('{1, 0, 32'd1536, 0, 1, "other way kept"});
    vecs.push_back('{0, 1, 32'd1600, 32'h12345678, 0, "write miss 1600"});
    vecs.push_back('{1, 0, 32'd1600, 0, 0, "no allocate 1600"});
    vecs.push_back('{1, 0, 32'd1600, 0, 1, "1600 now cached"});
    vecs.push_back('{1, 1, 32'd1024, 32'hCAFEF00D, 0, "rd+wr priority"});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready", ready, 1);
    check("reset sram_r_en", sram_r_en, 0);
    check("reset sram_w_en", sram_w_en, 0);

    foreach (vecs[i]) xact(vecs[i]);
    go_idle();

    // Reset while a fill is outstanding
    @(posedge clk); #1;
    MEM_R_EN = 1'b1; address = 32'd1024;
    @(negedge clk);
    check("rst-mid detect ready", ready, 0);
    @(posedge clk); #1;
    check("rst-mid sram_r_en before", sram_r_en, 1);
    #2 rst = 1'b1;
    #1 check("rst-mid sram_r_en async drop", sram_r_en, 0);
    MEM_R_EN = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    xact('{1, 0, 32'd1024, 0, 0, "post-rst 1024 miss"});
    xact('{1, 0, 32'd1536, 0, 0, "post-rst 1536 miss"});
    xact('{1, 0, 32'd1536, 0, 1, "post-rst 1536 hit"});
    go_idle();

    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache_controller.md
Name: data_cache_controller

Overview:
- Two-way set-associative, write-through, no-write-allocate data cache.
- Sits between the MEM pipeline stage (request from the EX/MEM register) and the SRAM controller.
- Serves read hits in zero added cycles. Forwards misses and all writes to the SRAM controller.
- Drives the pipeline-wide `ready` freeze signal.

Parameters:
- BASE_ADDR, 1024, start of the data region; the offset is address minus BASE_ADDR.
- INDEX_W, 6, set-index width (64 sets).
- TAG_W, 10, tag width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- MEM_R_EN  in  1  read request from MEM stage
- MEM_W_EN  in  1  write request from MEM stage
- address  in  32  byte address, word-aligned
- wdata  in  32  write data (val_Rm)
- rdata  out  32  read data to MEM/WB
- ready  out  1  0 = freeze pipeline
- sram_address  out  32  address to SRAM controller
- sram_wdata  out  32  write data to SRAM controller
- sram_r_en  out  1  line-read request
- sram_w_en  out  1  word-write request
- sram_rdata  in  64  aligned 2-word line; word0 is [31:0]
- sram_ready  in  1  SRAM access complete this cycle (1-cycle pulse)

Behaviour:
- Address split (off = address - BASE_ADDR):
  - word select = off[2]
  - index = off[8:3]
  - tag = off[18:9]
  - off[1:0] ignored
- Per set, per way: valid bit, TAG_W tag, 64-bit data. Per set: one `victim` bit naming the way to replace next.
- hit = (valid & tag match) in either way. Both ways matching cannot occur.
- FSM states: IDLE, READ_MISS, WRITE.
  - IDLE, MEM_W_EN=1 -> WRITE. Write has priority if MEM_R_EN is also 1.
  - IDLE, MEM_R_EN=1, miss -> READ_MISS.
  - IDLE, read hit -> stay.
  - READ_MISS: stay until sram_ready=1, then -> IDLE.
  - WRITE: stay until sram_ready=1, then -> IDLE.
- SRAM outputs:
  - sram_r_en = 1 whenever state = READ_MISS.
  - sram_w_en = 1 whenever state = WRITE.
  - sram_address = address and sram_wdata = wdata, passed through combinationally.
- ready (combinational):
  - 1 when no request.
  - 1 on an IDLE read hit.
  - 1 in the READ_MISS or WRITE cycle where sram_ready=1.
  - 0 otherwise, including the IDLE cycle in which a miss or write is first detected.
- rdata:
  - On a hit: the selected word of the hitting way.
  - In the READ_MISS completion cycle: the selected word of sram_rdata (bypass).
  - Otherwise don't-care, driven 0.
- Read hit on way w: at the clock edge, victim[index] <= ~w. No other state change.
- Read-miss fill, at the sram_ready edge:
  - Target way = first invalid way (way0 before way1), else victim[index].
  - Write the data and tag, set valid, then victim[index] <= ~target.
- Write:
  - If the address hits way w at WRITE entry, at the edge: valid[w] <= 0 and victim[index] <= w.
  - Write miss: no cache change (no allocate).
- The request is held stable by the frozen pipeline while ready=0. The block samples the index and tag from live inputs.
- Reset (async) and reset mid-operation:
  - state = IDLE; all valid bits = 0; all victim bits = 0.
  - sram_r_en = sram_w_en = 0 immediately; any in-flight fill is dropped.
  - Tag and data arrays need no reset.
- Back-to-back: a request presented in the cycle after completion is evaluated fresh in IDLE. A hit in that cycle returns ready=1 with no bubble.

Test Plan:
- Cold read of 1024 after reset:
  - ready=0 and sram_r_en=1 until sram_ready.
  - Completion-cycle rdata = sram_rdata[31:0] (e.g. 0x11111111), ready=1.
  - A read of 1028 next returns sram_rdata[63:32] with ready=1 the same cycle and no sram_r_en.
- Fill index 0 with tag 0 (addr 1024) and tag 1 (addr 1536), then re-read 1024, then read tag 2 (addr 2048):
  - The miss evicts the tag-1 way.
  - A read of 1024 still hits; a read of 1536 misses.
- Write 0xDEADBEEF to 1024 while cached:
  - sram_w_en=1, ready=0 until sram_ready.
  - The next read of 1024 misses and refills; victim[0] points to the invalidated way.
- Write to uncached 1600:
  - One SRAM write, ready pulses with sram_ready.
  - The next read of 1600 misses (no allocate).
- MEM_R_EN=1 and MEM_W_EN=1 together on 1024: FSM enters WRITE; sram_r_en stays 0.
- Assert rst during READ_MISS before sram_ready:
  - sram_r_en drops asynchronously.
  - After release, a read of the same address misses again (valid cleared).
